// File: rtl/wb_led_pwm.sv
// Wishbone-controlled PWM LED driver: prescaled PWM counter, duty compare,
// per-LED mask and an optional blink gate that toggles every 16 PWM periods.
module wb_led_pwm #(
  parameter int NUM_LEDS  = 8,
  parameter int PWM_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4:0]          adr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  input  logic                we_i,
  input  logic [3:0]          sel_i,
  input  logic                stb_i,
  input  logic                cyc_i,
  output logic                ack_o,
  output logic                err_o,
  output logic [NUM_LEDS-1:0] led_o
);

  localparam logic [PWM_WIDTH-1:0] CNT_MAX  = {PWM_WIDTH{1'b1}};
  localparam logic [PWM_WIDTH-1:0] DUTY_RST = {1'b1, {(PWM_WIDTH-1){1'b0}}};
  localparam logic [15:0]          PERIOD_RST = 16'h03E7;

  logic                 en_q, en_d, blink_q, blink_d;
  logic [15:0]          period_q, period_d, presc_q, presc_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d, cnt_q, cnt_d;
  logic [NUM_LEDS-1:0]  mask_q, mask_d, led_q, led_d;
  logic [3:0]           wrap_q, wrap_d;
  logic                 phase_q, phase_d;
  logic                 ack_q, ack_d, err_q, err_d;
  logic [31:0]          dat_q, dat_d;

  logic        req_s, valid_s, wr_s, tick_s, pwm_on_s, unused_s;
  logic [2:0]  idx_s;
  logic [31:0] rdata_s, merged_s;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
      else        r[8*b +: 8] = old_v[8*b +: 8];
    end
    return r;
  endfunction

  // A new request is only accepted while no termination is being presented.
  assign req_s    = stb_i & cyc_i & ~ack_q & ~err_q;
  assign idx_s    = adr_i[4:2];
  assign valid_s  = (idx_s <= 3'd4);
  assign wr_s     = req_s & we_i & valid_s;
  assign merged_s = merge_lanes(rdata_s, dat_i, sel_i);
  assign tick_s   = en_q & (presc_q == 16'd0);
  assign pwm_on_s = (cnt_q < duty_q);
  assign unused_s = ^{adr_i[1:0], merged_s};

  // Read multiplexer
  always_comb begin
    rdata_s = 32'd0;
    case (idx_s)
      3'd0:    rdata_s = {30'd0, blink_q, en_q};
      3'd1:    rdata_s = {16'd0, period_q};
      3'd2:    rdata_s = 32'(duty_q);
      3'd3:    rdata_s = 32'(mask_q);
      3'd4:    rdata_s = 32'(cnt_q) | (32'(phase_q) << 16);
      default: rdata_s = 32'd0;
    endcase
  end

  // Control register writes and bus termination
  always_comb begin
    en_d     = en_q;
    blink_d  = blink_q;
    period_d = period_q;
    duty_d   = duty_q;
    mask_d   = mask_q;
    if (wr_s) begin
      case (idx_s)
        3'd0: begin
          en_d    = merged_s[0];
          blink_d = merged_s[1];
        end
        3'd1:    period_d = merged_s[15:0];
        3'd2:    duty_d   = merged_s[PWM_WIDTH-1:0];
        3'd3:    mask_d   = merged_s[NUM_LEDS-1:0];
        default: period_d = period_q;
      endcase
    end else begin
      en_d = en_q;
    end
    ack_d = req_s & valid_s;
    err_d = req_s & ~valid_s;
    if (req_s & valid_s & ~we_i) dat_d = rdata_s;
    else                         dat_d = 32'd0;
  end

  // Prescaler, PWM counter, wrap counter and blink phase
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    phase_d = phase_q;
    if (!en_q) begin
      presc_d = period_q;
      cnt_d   = {PWM_WIDTH{1'b0}};
      wrap_d  = 4'd0;
      phase_d = 1'b0;
    end else if (tick_s) begin
      presc_d = period_q;
      cnt_d   = cnt_q + PWM_WIDTH'(1);
      if (cnt_q == CNT_MAX) begin
        wrap_d = wrap_q + 4'd1;
        if (wrap_q == 4'hF) phase_d = ~phase_q;
        else                phase_d = phase_q;
      end else begin
        wrap_d = wrap_q;
      end
    end else begin
      presc_d = presc_q - 16'd1;
    end
    if (en_q & pwm_on_s & (~blink_q | phase_q)) led_d = mask_q;
    else                                        led_d = {NUM_LEDS{1'b0}};
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q     <= 1'b0;
      blink_q  <= 1'b0;
      period_q <= PERIOD_RST;
      duty_q   <= DUTY_RST;
      mask_q   <= {NUM_LEDS{1'b0}};
      presc_q  <= PERIOD_RST;
      cnt_q    <= {PWM_WIDTH{1'b0}};
      wrap_q   <= 4'd0;
      phase_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= 32'd0;
      led_q    <= {NUM_LEDS{1'b0}};
    end else begin
      en_q     <= en_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      mask_q   <= mask_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      phase_q  <= phase_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      led_q    <= led_d;
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = dat_q;
  assign led_o = led_q;

endmodule

// File: tb/tb_wb_led_pwm.sv
// Self-checking bench for wb_led_pwm: register-map vector table, bus corner
// sequences, and PWM output checked against a closed-form timing model.
module tb_wb_led_pwm;

  localparam int NL = 8;
  localparam int PW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    adr_i = 5'd0;
  logic [31:0]   dat_i = 32'd0;
  logic [31:0]   dat_o;
  logic          we_i  = 1'b0;
  logic [3:0]    sel_i = 4'd0;
  logic          stb_i = 1'b0;
  logic          cyc_i = 1'b0;
  logic          ack_o, err_o;
  logic [NL-1:0] led_o;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc_n  = 0;

  // Model of the programmed configuration; en_edge is the edge that set EN.
  int unsigned m_p = 0, m_d = 0, en_edge = 0;
  logic [7:0]  m_m = 8'd0;
  bit          m_b = 1'b0, m_en = 1'b0;

  wb_led_pwm #(.NUM_LEDS(NL), .PWM_WIDTH(PW)) dut (
    .clock(clock), .reset(reset), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i),
    .ack_o(ack_o), .err_o(err_o), .led_o(led_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  typedef struct packed {
    logic [4:0]  adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Ticks after k enabled edges: one per PERIOD+1 edges; phase flips every 16*256 ticks.
  function automatic logic [7:0] exp_led(input int unsigned k);
    int unsigned n;
    n = (k - 1) / (m_p + 1);
    if (!m_en || k < 1) return 8'd0;
    if (((n % 256) < m_d) && (!m_b || ((n / 4096) % 2 == 1))) return m_m;
    return 8'd0;
  endfunction

  function automatic logic [31:0] exp_status(input int unsigned k);
    int unsigned n;
    n = k / (m_p + 1);
    if (!m_en) return 32'd0;
    return ((n / 4096) % 2 == 1 ? 32'h0001_0000 : 32'd0) | (n % 256);
  endfunction

  task automatic wb(input logic [4:0] a, input logic we, input logic [3:0] sel,
                    input logic [31:0] wd, output logic ack, output logic err,
                    output logic [31:0] rd, output int unsigned s);
    @(negedge clock);
    check("idle_term", {30'd0, ack_o, err_o}, 32'd0);
    adr_i = a; we_i = we; sel_i = sel; dat_i = wd; stb_i = 1'b1; cyc_i = 1'b1;
    @(posedge clock); #1;
    ack = ack_o; err = err_o; rd = dat_o; s = cyc_n;
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    @(posedge clock); #1;
    check("term_one_cycle", {30'd0, ack_o, err_o}, 32'd0);
    check("dat_o_idle", dat_o, 32'd0);
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] wd, output int unsigned s);
    logic ack, err;
    logic [31:0] rd;
    wb(a, 1'b1, 4'hF, wd, ack, err, rd, s);
    check($sformatf("wr_ack_%02h", a), {30'd0, ack, err}, 32'd2);
  endtask

  task automatic reg_rd(input logic [4:0] a, input logic [31:0] exp);
    logic ack, err;
    logic [31:0] rd;
    int unsigned s;
    wb(a, 1'b0, 4'hF, 32'd0, ack, err, rd, s);
    check($sformatf("rd_ack_%02h", a), {30'd0, ack, err}, 32'd2);
    check($sformatf("rd_data_%02h", a), rd, exp);
  endtask

  task automatic rd_status(input string name);
    logic ack, err;
    logic [31:0] rd;
    int unsigned s;
    wb(5'h10, 1'b0, 4'hF, 32'd0, ack, err, rd, s);
    check(name, rd, exp_status(s - 1 - en_edge));
  endtask

  task automatic run_leds(input int unsigned n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      check(name, 32'(led_o), 32'(exp_led(cyc_n - en_edge)));
    end
  endtask

  task automatic configure(input int unsigned p, input int unsigned d,
                           input logic [7:0] m, input bit b);
    int unsigned s;
    reg_wr(5'h00, 32'd0, s);
    m_en = 1'b0;
    reg_wr(5'h04, 32'(p), s);
    reg_wr(5'h08, 32'(d), s);
    reg_wr(5'h0C, 32'(m), s);
    m_p = p; m_d = d; m_m = m; m_b = b;
    reg_wr(5'h00, {30'd0, b, 1'b1}, s);
    m_en = 1'b1; en_edge = s;
  endtask

  initial begin
    logic ack, err;
    logic [31:0] rd;
    logic [2:0]  acks;
    int unsigned s, hi;

    tbl.push_back('{5'h00, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h04, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_03E7});
    tbl.push_back('{5'h08, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_0080});
    tbl.push_back('{5'h0C, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h10, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h0C, 1'b1, 4'h1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h0C, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_00FF});
    tbl.push_back('{5'h14, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000});
    tbl.push_back('{5'h14, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0000_0000});
    tbl.push_back('{5'h18, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0000_0000});
    tbl.push_back('{5'h1C, 1'b1, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0000_0000});
    tbl.push_back('{5'h0C, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_00FF});
    tbl.push_back('{5'h04, 1'b1, 4'hC, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h04, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_03E7});
    tbl.push_back('{5'h04, 1'b1, 4'h3, 32'hAABB_1234, 1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h04, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_1234});
    tbl.push_back('{5'h08, 1'b1, 4'hF, 32'h0000_01FF, 1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h08, 1'b1, 4'h2, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h08, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_00FF});
    tbl.push_back('{5'h10, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h10, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h00, 1'b1, 4'hF, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h00, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h00, 1'b1, 4'h1, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0000});
    tbl.push_back('{5'h00, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_0002});
    tbl.push_back('{5'h00, 1'b1, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0000_0000});

    // Power-on reset
    #1 reset = 1'b0;
    #2;
    check("rst_term", {30'd0, ack_o, err_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_led", 32'(led_o), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      wb(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].wd, ack, err, rd, s);
      check($sformatf("tbl%0d_term", i), {30'd0, ack, err},
            {30'd0, tbl[i].exp_ack, tbl[i].exp_err});
      check($sformatf("tbl%0d_data", i), rd, tbl[i].exp_rd);
    end

    // Request held through the termination cycle: terminated every other cycle
    @(negedge clock);
    adr_i = 5'h04; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      acks[i] = ack_o;
    end
    check("held_dat", dat_o, 32'h0000_1234);
    stb_i = 1'b0; cyc_i = 1'b0;
    check("held_ack_pattern", 32'(acks), 32'd5);
    @(posedge clock); #1;

    // cyc_i dropped before the sampling edge, and stb_i without cyc_i
    @(negedge clock);
    adr_i = 5'h0C; we_i = 1'b1; dat_i = 32'h0000_0055; stb_i = 1'b1; cyc_i = 1'b1;
    #2 cyc_i = 1'b0;
    @(posedge clock); #1;
    check("drop_no_term", {30'd0, ack_o, err_o}, 32'd0);
    @(posedge clock); #1;
    check("drop_no_term2", {30'd0, ack_o, err_o}, 32'd0);
    stb_i = 1'b0; we_i = 1'b0;
    reg_rd(5'h0C, 32'h0000_00FF);

    // One LED at 64/256 duty, tick every cycle
    configure(0, 32'h40, 8'h01, 1'b0);
    hi = 0;
    for (int i = 0; i < 512; i++) begin
      @(posedge clock); #1;
      check("pwm64_led", 32'(led_o), 32'(exp_led(cyc_n - en_edge)));
      if (i < 256 && led_o[0]) hi++;
    end
    check("pwm64_high_count", hi, 32'd64);
    rd_status("pwm64_status_a");
    rd_status("pwm64_status_b");

    // Disable mid-period, then re-enable with a longer prescale
    configure(5, 32'h80, 8'hA5, 1'b0);
    run_leds(100, "p5_led");
    rd_status("p5_status");
    reg_wr(5'h00, 32'd0, s);
    m_en = 1'b0;
    check("dis_led", 32'(led_o), 32'd0);
    reg_rd(5'h10, 32'd0);
    reg_wr(5'h00, 32'd1, s);
    m_en = 1'b1; en_edge = s;
    rd_status("reen_status_first");
    run_leds(40, "reen_led");
    rd_status("reen_status_later");

    // Randomized configurations against the model
    for (int t = 0; t < 6; t++) begin
      configure($urandom_range(0, 3), $urandom_range(0, 255),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      run_leds(300, $sformatf("rand%0d_led", t));
      rd_status($sformatf("rand%0d_status", t));
    end

    // Blink: dark for 4096 ticks, then PWM at duty 255
    configure(0, 32'hFF, 8'hFF, 1'b1);
    hi = 0;
    for (int i = 0; i < 8400; i++) begin
      @(posedge clock); #1;
      check("blink_led", 32'(led_o), 32'(exp_led(cyc_n - en_edge)));
      if (i < 4000 && led_o != 8'd0) hi++;
    end
    check("blink_dark_count", hi, 32'd0);
    rd_status("blink_status");

    // Reset pulse in the middle of a write
    @(negedge clock);
    adr_i = 5'h08; we_i = 1'b1; sel_i = 4'hF; dat_i = 32'h11; stb_i = 1'b1; cyc_i = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_term", {30'd0, ack_o, err_o}, 32'd0);
    check("mid_rst_led", 32'(led_o), 32'd0);
    check("mid_rst_dat", dat_o, 32'd0);
    @(posedge clock); #1;
    check("mid_rst_term2", {30'd0, ack_o, err_o}, 32'd0);
    @(negedge clock);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    reset = 1'b1;
    m_en = 1'b0;
    reg_rd(5'h08, 32'h0000_0080);
    reg_rd(5'h00, 32'h0000_0000);
    reg_rd(5'h04, 32'h0000_03E7);
    reg_rd(5'h0C, 32'h0000_0000);
    reg_rd(5'h10, 32'h0000_0000);
    check("post_rst_led", 32'(led_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_led_pwm.md
WB_LED_PWM -- requirements
Module: wb_led_pwm

Interface
REQ-001 The block SHALL be parameterised as: NUM_LEDS, default 8, LED output count (1..32).
REQ-002 The block SHALL be parameterised as: PWM_WIDTH, default 8, PWM counter and duty width (4..16).
REQ-003 The block SHALL have port: clock  in  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port: adr_i  in  5  Wishbone byte address; only bits [4:2] are decoded.
REQ-006 The block SHALL have port: dat_i  in  32  Wishbone write data.
REQ-007 The block SHALL have port: dat_o  out  32  Wishbone read data.
REQ-008 The block SHALL have port: we_i  in  1  write enable.
REQ-009 The block SHALL have port: sel_i  in  4  byte lane enables.
REQ-010 The block SHALL have port: stb_i  in  1  strobe.
REQ-011 The block SHALL have port: cyc_i  in  1  cycle valid.
REQ-012 The block SHALL have port: ack_o  out  1  normal termination.
REQ-013 The block SHALL have port: err_o  out  1  error termination.
REQ-014 The block SHALL have port: led_o  out  NUM_LEDS  LED drive, active-high.

Function
REQ-015 The register map SHALL be: 0x00 CTRL (bit0 EN, bit1 BLINK); 0x04 PERIOD [15:0]; 0x08 DUTY [PWM_WIDTH-1:0]; 0x0C MASK [NUM_LEDS-1:0]; 0x10 STATUS (read-only: [PWM_WIDTH-1:0] pwm_cnt, bit16 blink phase).
REQ-016 A request SHALL be stb_i & cyc_i with ack_o and err_o both low; the termination SHALL be registered and SHALL last exactly one cycle, asserted in the cycle after the request is sampled.
REQ-017 Every access SHALL therefore take 2 cycles; a request held high through the termination cycle SHALL NOT be re-terminated in that cycle.
REQ-018 Addresses 0x14-0x1C SHALL terminate with err_o instead of ack_o, with no state change and dat_o = 0.
REQ-019 Writes SHALL update only the byte lanes enabled by sel_i, at the clock edge that asserts ack_o; unimplemented bits SHALL be ignored and SHALL read 0.
REQ-020 A write to STATUS SHALL be acknowledged and ignored.
REQ-021 dat_o SHALL be registered with the termination and SHALL hold 0 in all other cycles.
REQ-022 If cyc_i or stb_i drops before termination, no termination SHALL be issued and no write SHALL occur.
REQ-023 When EN=1, the 16-bit prescaler SHALL count down from PERIOD to 0 and issue a one-cycle tick on reaching 0, then reload PERIOD; PERIOD=0 SHALL give a tick every cycle.
REQ-024 A PERIOD write SHALL take effect only at the next reload.
REQ-025 pwm_cnt SHALL increment on each tick and wrap from 2^PWM_WIDTH-1 to 0.
REQ-026 Each wrap SHALL increment a 4-bit wrap counter; the blink phase SHALL toggle when that counter wraps (every 16 PWM periods).
REQ-027 pwm_on SHALL be (pwm_cnt < DUTY): DUTY=0 gives always off; DUTY=2^PWM_WIDTH-1 gives off for 1 count per period.
REQ-028 led_o[i] SHALL be registered and equal EN & MASK[i] & pwm_on & (~BLINK | phase).
REQ-029 When EN=0, the prescaler SHALL be loaded with PERIOD, pwm_cnt, the wrap counter and phase SHALL be held at 0, and led_o SHALL be 0 from the next cycle.
REQ-030 A bus write and a tick in the same cycle SHALL both take effect; the new DUTY or MASK value SHALL affect led_o no earlier than the following cycle.

Reset
REQ-031 While reset=0, regardless of clock: CTRL=0, PERIOD=0x03E7, DUTY=2^(PWM_WIDTH-1), MASK=0, prescaler=0x03E7, pwm_cnt=0, wrap counter=0, phase=0, ack_o=0, err_o=0, dat_o=0, led_o=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no termination; after deassertion the next request SHALL be served normally.

Verification
REQ-033 Read every register after reset -> 0x0, 0x3E7, 0x80, 0x0, 0x0; each ack_o exactly 1 cycle, 1 cycle after the request.
REQ-034 Write MASK=0xFFFFFFFF with sel_i=0001 -> readback 0x000000FF; write to 0x14 -> err_o pulse, ack_o=0, no register change.
REQ-035 PERIOD=0, DUTY=0x40, MASK=0x01, CTRL=1 -> led_o[0] high 64 and low 192 of every 256 cycles; STATUS pwm_cnt advances 1 per cycle.
REQ-036 CTRL=3, PERIOD=0, DUTY=0xFF -> led_o all 0 for 4096 cycles, then PWM for 4096 cycles, repeating.
REQ-037 Clear EN mid-period, then set it again -> led_o=0 the next cycle; STATUS=0; restart from pwm_cnt=0 with a full PERIOD prescale.
REQ-038 Drop cyc_i the cycle after a write request, and separately pulse reset low mid-write -> no ack, register unchanged, all outputs at reset values.
